alu_issue_ctrl: RTL and testbench

//  Shares the single 32-bit ALU between two requesters (req0 = execute stage, req1 = debug/DMA port).

---
 rtl/fc_alu_pkg.sv | 37 +++
 rtl/fc_rr_arb2.sv | 32 +++
 rtl/alu_issue_ctrl.sv | 146 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_alu_pkg.sv
// Shared definitions for the ALU issue controller: opcode map, FSM states,
// flag bit positions and the opcode legality check.
package fc_alu_pkg;

  localparam logic [4:0] OP_NOP = 5'd0;
  localparam logic [4:0] OP_AND = 5'd1;
  localparam logic [4:0] OP_OR  = 5'd2;
  localparam logic [4:0] OP_XOR = 5'd3;
  localparam logic [4:0] OP_NOT = 5'd4;
  localparam logic [4:0] OP_SHL = 5'd5;
  localparam logic [4:0] OP_SHR = 5'd6;
  localparam logic [4:0] OP_SAR = 5'd7;
  localparam logic [4:0] OP_ROL = 5'd8;
  localparam logic [4:0] OP_ROR = 5'd9;
  localparam logic [4:0] OP_ADD = 5'd16;
  localparam logic [4:0] OP_SUB = 5'd17;
  localparam logic [4:0] OP_INC = 5'd18;
  localparam logic [4:0] OP_DEC = 5'd19;

  localparam int FLAG_CARRY  = 0;
  localparam int FLAG_OVF    = 1;
  localparam int FLAG_PARITY = 2;
  localparam int FLAG_NEG    = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Two legal bands: logic/shift ops 0-9 and arithmetic ops 16-19.
  function automatic logic is_legal_op(input logic [7:0] op);
    return (op <= 8'({3'b000, OP_ROR})) ||
           ((op >= 8'({3'b000, OP_ADD})) && (op <= 8'({3'b000, OP_DEC})));
  endfunction

endpackage

// File: rtl/fc_rr_arb2.sv
// Two-way arbiter: round-robin on ties (or fixed req0 priority), with the
// last-winner register updated only when a grant is actually taken.
module fc_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fixed_pri,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (fixed_pri || last_grant_q) ? 2'b01 : 2'b10;
    end
    last_grant_d = accept ? grant[1] : last_grant_q;
  end

  // Reset value 1 makes req0 the winner of the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Shares one ALU between two requesters: arbitrate, drive the ALU for a
// single EXEC cycle, then hold the captured response until consumed.
module alu_issue_ctrl
  import fc_alu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int OPW       = 5,
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [WIDTH-1:0] alu_op_a,
  output logic [WIDTH-1:0] alu_op_b,
  output logic [OPW-1:0]   alu_op_code,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [3:0]       alu_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic [3:0]       rsp_flags,
  output logic             rsp_err,
  output state_t           dbg_state
);

  // Handshake: a request transfers on a cycle where reqN_valid && reqN_ready;
  // a response transfers on a cycle where rsp_valid && rsp_ready.
  state_t           state_q, state_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [3:0]       rsp_flags_q, rsp_flags_d;
  logic             rsp_err_q, rsp_err_d;

  logic [1:0]       grant;
  logic             in_idle;
  logic             accept;
  logic [OPW-1:0]   sel_op;
  logic [WIDTH-1:0] sel_a, sel_b;

  fc_rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .fixed_pri (FIXED_PRI),
    .req       ({req1_valid, req0_valid}),
    .accept    (accept),
    .grant     (grant)
  );

  // Gating with rst_n keeps ready low while reset is held.
  assign in_idle    = (state_q == ST_IDLE) && rst_n;
  assign accept     = in_idle && (grant != 2'b00);
  assign req0_ready = in_idle && grant[0];
  assign req1_ready = in_idle && grant[1];

  assign sel_op = grant[1] ? req1_op : req0_op;
  assign sel_a  = grant[1] ? req1_a  : req0_a;
  assign sel_b  = grant[1] ? req1_b  : req0_b;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    rsp_data_d  = rsp_data_q;
    rsp_flags_d = rsp_flags_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d = sel_op;
          a_d  = sel_a;
          b_d  = sel_b;
          id_d = grant[1];
          if (is_legal_op(8'(sel_op))) begin
            state_d = ST_EXEC;
          end else begin
            rsp_data_d  = '0;
            rsp_flags_d = '0;
            rsp_err_d   = 1'b1;
            state_d     = ST_RESP;
          end
        end
      end
      ST_EXEC: begin
        rsp_data_d  = alu_out;
        rsp_flags_d = alu_flags;
        rsp_err_d   = 1'b0;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= 1'b0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Outside EXEC the ALU sees a NOP with zero operands.
  assign alu_op_code = (state_q == ST_EXEC) ? op_q : '0;
  assign alu_op_a    = (state_q == ST_EXEC) ? a_q  : '0;
  assign alu_op_b    = (state_q == ST_EXEC) ? b_q  : '0;

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_id    = id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_flags = rsp_flags_q;
  assign rsp_err   = rsp_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small stand-in ALU model.
module tb_alu_issue_ctrl;
  import fc_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_op = '0, req1_op = '0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [31:0] alu_op_a, alu_op_b, alu_out;
  logic [4:0]  alu_op_code;
  logic [3:0]  alu_flags;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_err;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_flags;
  state_t      dbg_state;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  alu_issue_ctrl #(.WIDTH(32), .OPW(5), .FIXED_PRI(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_op_code(alu_op_code),
    .alu_out(alu_out), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .dbg_state(dbg_state)
  );

  // Stand-in ALU: add/sub with {neg, parity, overflow, carry}; op 0 yields 0.
  logic [32:0] wide;
  logic        ovf;
  always_comb begin
    wide = '0;
    ovf  = 1'b0;
    case (alu_op_code)
      5'd0:  wide = '0;
      5'd16: begin
        wide = {1'b0, alu_op_a} + {1'b0, alu_op_b};
        ovf  = (alu_op_a[31] == alu_op_b[31]) && (wide[31] != alu_op_a[31]);
      end
      5'd17: begin
        wide = {1'b0, alu_op_a} - {1'b0, alu_op_b};
        ovf  = (alu_op_a[31] != alu_op_b[31]) && (wide[31] != alu_op_a[31]);
      end
      default: wide = {1'b0, alu_op_a ^ alu_op_b};
    endcase
  end
  assign alu_out   = wide[31:0];
  assign alu_flags = {wide[31], ^wide[31:0], ovf, wide[32]};

  task automatic drive_req(input int who, input logic [4:0] op,
                           input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    if (who == 0) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end
  endtask

  task automatic clear_req();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic consume_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({req0_ready, req1_ready, rsp_valid, rsp_err, rsp_id} !== 5'b0 ||
        alu_op_code !== 5'd0 || rsp_data !== 32'd0 || rsp_flags !== 4'd0 ||
        dbg_state !== ST_IDLE) begin
      $display("FAIL reset_outputs: ready=%b%b rsp_valid=%b op=%0d data=%h state=%0d, want all 0",
               req0_ready, req1_ready, rsp_valid, alu_op_code, rsp_data, dbg_state);
      miscompares++;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    drive_req(0, 5'd16, 32'd5, 32'd7);
    #1;
    vectors++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || alu_op_code !== 5'd0) begin
      $display("FAIL basic_ready: ready0=%b ready1=%b op=%0d, want 1 0 0",
               req0_ready, req1_ready, alu_op_code);
      miscompares++;
    end
    @(negedge clk);
    clear_req();
    vectors++;
    if (alu_op_code !== 5'd16 || alu_op_a !== 32'd5 || alu_op_b !== 32'd7 ||
        rsp_valid !== 1'b0 || dbg_state !== ST_EXEC) begin
      $display("FAIL basic_exec: op=%0d a=%0d b=%0d rsp_valid=%b state=%0d, want 16 5 7 0 1",
               alu_op_code, alu_op_a, alu_op_b, rsp_valid, dbg_state);
      miscompares++;
    end
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'd12 || rsp_id !== 1'b0 ||
        rsp_err !== 1'b0 || rsp_flags !== 4'b0000 || alu_op_code !== 5'd0) begin
      $display("FAIL basic_rsp: valid=%b data=%0d id=%b err=%b flags=%b op=%0d, want 1 12 0 0 0000 0",
               rsp_valid, rsp_data, rsp_id, rsp_err, rsp_flags, alu_op_code);
      miscompares++;
    end
    consume_rsp();
    vectors++;
    if (rsp_valid !== 1'b0 || dbg_state !== ST_IDLE) begin
      $display("FAIL basic_consume: rsp_valid=%b state=%0d, want 0 0", rsp_valid, dbg_state);
      miscompares++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_data [4];
    exp_data[0] = 32'd11; exp_data[1] = 32'd22; exp_data[2] = 32'd12; exp_data[3] = 32'd23;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_op = 5'd16; req0_a = 32'd10; req0_b = 32'd1;
    req1_valid = 1'b1; req1_op = 5'd16; req1_a = 32'd20; req1_b = 32'd2;
    rsp_ready  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      vectors++;
      if (req0_ready !== (k % 2 == 0) || req1_ready !== (k % 2 == 1)) begin
        $display("FAIL b2b_grant[%0d]: ready0=%b ready1=%b, want %b %b",
                 k, req0_ready, req1_ready, k % 2 == 0, k % 2 == 1);
        miscompares++;
      end
      exp_q.push_back(exp_data[k]);
      @(negedge clk);
      if (k % 2 == 0) req0_a = req0_a + 32'd1;
      else            req1_a = req1_a + 32'd1;
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'(k % 2) || rsp_data !== exp_q[0]) begin
        $display("FAIL b2b_rsp[%0d]: valid=%b id=%b data=%0d, want 1 %0d %0d",
                 k, rsp_valid, rsp_id, rsp_data, k % 2, exp_q[0]);
        miscompares++;
      end
      void'(exp_q.pop_front());
      @(negedge clk);
    end
    clear_req();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reserved();
    drive_req(1, 5'd12, 32'hAAAA_5555, 32'h1234_5678);
    #1;
    vectors++;
    if (req1_ready !== 1'b1 || alu_op_code !== 5'd0) begin
      $display("FAIL rsv_ready: ready1=%b op=%0d, want 1 0", req1_ready, alu_op_code);
      miscompares++;
    end
    @(negedge clk);
    clear_req();
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 32'd0 ||
        rsp_flags !== 4'd0 || rsp_id !== 1'b1 || alu_op_code !== 5'd0) begin
      $display("FAIL rsv_rsp: valid=%b err=%b data=%h flags=%b id=%b op=%0d, want 1 1 0 0 1 0",
               rsp_valid, rsp_err, rsp_data, rsp_flags, rsp_id, alu_op_code);
      miscompares++;
    end
    consume_rsp();
  endtask

  task automatic test_legality();
    logic [4:0] ops [8];
    logic       legal [8];
    ops[0] = 5'd0;  legal[0] = 1'b1;
    ops[1] = 5'd9;  legal[1] = 1'b1;
    ops[2] = 5'd10; legal[2] = 1'b0;
    ops[3] = 5'd15; legal[3] = 1'b0;
    ops[4] = 5'd16; legal[4] = 1'b1;
    ops[5] = 5'd19; legal[5] = 1'b1;
    ops[6] = 5'd20; legal[6] = 1'b0;
    ops[7] = 5'd31; legal[7] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive_req(0, ops[i], 32'd3, 32'd4);
      @(negedge clk);
      clear_req();
      vectors++;
      if (rsp_valid !== !legal[i] || alu_op_code !== (legal[i] ? ops[i] : 5'd0)) begin
        $display("FAIL legal_t1[op=%0d]: rsp_valid=%b alu_op=%0d, want %b %0d",
                 ops[i], rsp_valid, alu_op_code, !legal[i], legal[i] ? ops[i] : 5'd0);
        miscompares++;
      end
      if (legal[i]) @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_err !== !legal[i]) begin
        $display("FAIL legal_rsp[op=%0d]: rsp_valid=%b err=%b, want 1 %b",
                 ops[i], rsp_valid, rsp_err, !legal[i]);
        miscompares++;
      end
      consume_rsp();
    end
  endtask

  task automatic test_hold();
    drive_req(0, 5'd16, 32'h7FFF_FFFF, 32'd1);
    @(negedge clk);
    clear_req();
    @(negedge clk);
    req0_valid = 1'b1; req0_op = 5'd16; req0_a = 32'd1; req0_b = 32'd1;
    req1_valid = 1'b1; req1_op = 5'd17; req1_a = 32'd9; req1_b = 32'd2;
    for (int c = 0; c < 10; c++) begin
      #1;
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h8000_0000 || rsp_flags !== 4'b1110 ||
          rsp_id !== 1'b0 || rsp_err !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        $display("FAIL hold[%0d]: valid=%b data=%h flags=%b id=%b ready=%b%b, want 1 80000000 1110 0 00",
                 c, rsp_valid, rsp_data, rsp_flags, rsp_id, req0_ready, req1_ready);
        miscompares++;
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    clear_req();
    rsp_ready = 1'b0;
    vectors++;
    if (rsp_valid !== 1'b0 || dbg_state !== ST_IDLE) begin
      $display("FAIL hold_release: rsp_valid=%b state=%0d, want 0 0", rsp_valid, dbg_state);
      miscompares++;
    end
  endtask

  task automatic test_reset_mid_op();
    drive_req(0, 5'd17, 32'd9, 32'd4);
    @(negedge clk);
    vectors++;
    if (alu_op_code !== 5'd17 || dbg_state !== ST_EXEC) begin
      $display("FAIL rst_pre: op=%0d state=%0d, want 17 1", alu_op_code, dbg_state);
      miscompares++;
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (alu_op_code !== 5'd0 || alu_op_a !== 32'd0 || rsp_valid !== 1'b0 ||
        req0_ready !== 1'b0 || rsp_data !== 32'd0 || dbg_state !== ST_IDLE) begin
      $display("FAIL rst_async: op=%0d a=%0d rsp_valid=%b ready0=%b data=%h state=%0d, want all 0",
               alu_op_code, alu_op_a, rsp_valid, req0_ready, rsp_data, dbg_state);
      miscompares++;
    end
    clear_req();
    @(negedge clk);
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_op = 5'd16; req0_a = 32'd1; req0_b = 32'd2;
    req1_valid = 1'b1; req1_op = 5'd16; req1_a = 32'd3; req1_b = 32'd4;
    #1;
    vectors++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      $display("FAIL rst_tie: ready0=%b ready1=%b, want 1 0", req0_ready, req1_ready);
      miscompares++;
    end
    @(negedge clk);
    clear_req();
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 32'd3) begin
      $display("FAIL rst_after: valid=%b id=%b data=%0d, want 1 0 3", rsp_valid, rsp_id, rsp_data);
      miscompares++;
    end
    consume_rsp();
  endtask

  task automatic test_carry();
    drive_req(1, 5'd16, 32'hFFFF_FFFF, 32'd1);
    @(negedge clk);
    clear_req();
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'd0 || rsp_flags !== 4'b0001 ||
        rsp_id !== 1'b1 || rsp_err !== 1'b0) begin
      $display("FAIL carry: valid=%b data=%h flags=%b id=%b err=%b, want 1 0 0001 1 0",
               rsp_valid, rsp_data, rsp_flags, rsp_id, rsp_err);
      miscompares++;
    end
    consume_rsp();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_reserved();
    test_legality();
    test_hold();
    test_reset_mid_op();
    test_carry();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
